// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: width codes, error causes,
// FSM states and the store byte-lane enable lookup.
package dmem_pkg;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  localparam logic [1:0] W_INV  = 2'b11;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_MISAL = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RD_WAIT = 2'b01,
    S_DONE    = 2'b10
  } state_e;

  function automatic logic [3:0] lane_en(input logic [1:0] width, input logic [1:0] off);
    case (width)
      W_BYTE:  return 4'b0001 << off;
      W_HALF:  return off[1] ? 4'b1100 : 4'b0011;
      W_WORD:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: replicates store data across lanes with matching byte
// enables, and extracts/extends a load result from the returned SRAM word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  st_width,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_width,
  input  logic        ld_unsigned,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;
  logic        sext;

  always_comb begin
    st_be = lane_en(st_width, st_off);
    case (st_width)
      W_BYTE:  st_wdata = {4{st_data[7:0]}};
      W_HALF:  st_wdata = {2{st_data[15:0]}};
      default: st_wdata = st_data;
    endcase
  end

  // Selected lane lands in the low bits; the sign bit depends on the width.
  always_comb begin
    shifted = ld_word >> {ld_off, 3'b000};
    sext    = 1'b0;
    case (ld_width)
      W_BYTE: begin
        sext    = ~ld_unsigned & shifted[7];
        ld_data = {{24{sext}}, shifted[7:0]};
      end
      W_HALF: begin
        sext    = ~ld_unsigned & shifted[15];
        ld_data = {{16{sext}}, shifted[15:0]};
      end
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller behind the MEM stage: posts stores in one cycle,
// stalls loads until SRAM data returns, and flags bad requests.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LAT      = 1,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_re,
  input  logic          req_we,
  input  logic [1:0]    req_width,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          stall_out,
  output logic          load_valid,
  output logic [31:0]   load_data,
  output logic          err_out,
  output logic [1:0]    err_cause,
  output logic          sram_en,
  output logic [3:0]    sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
  localparam logic [1:0]  CNT_INIT = 2'(RD_LAT - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  width_q, off_q;
  logic        uns_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [1:0]  cause_q;

  logic [31:0] off_full;
  logic        illegal, misal, oor;
  logic [1:0]  cause;
  logic        sample, good, st_go, ld_go;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  always_comb begin
    off_full = req_addr - BASE_ADDR;
    illegal  = (req_re & req_we) | (req_width == W_INV);
    misal    = ((req_width == W_HALF) & req_addr[0]) |
               ((req_width == W_WORD) & (req_addr[1:0] != 2'b00));
    oor      = (req_addr < BASE_ADDR) | (off_full >= SPAN);
    if (illegal)    cause = ERR_ILL;
    else if (misal) cause = ERR_MISAL;
    else if (oor)   cause = ERR_RANGE;
    else            cause = ERR_NONE;
    // rst_n gates the input-driven paths so outputs read 0 throughout reset.
    sample = rst_n & (state_q == S_IDLE) & (req_re | req_we);
    good   = sample & (cause == ERR_NONE);
    st_go  = good & req_we;
    ld_go  = good & req_re;
  end

  dmem_lane_align u_align (
    .st_width    (req_width),
    .st_off      (req_addr[1:0]),
    .st_data     (req_wdata),
    .st_be       (st_be),
    .st_wdata    (st_wdata),
    .ld_width    (width_q),
    .ld_unsigned (uns_q),
    .ld_off      (off_q),
    .ld_word     (rdata_q),
    .ld_data     (ld_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_out  = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    sram_en    = 1'b0;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (st_go) begin
          sram_en    = 1'b1;
          sram_we    = st_be;
          sram_addr  = off_full[AW+1:2];
          sram_wdata = st_wdata;
        end else if (ld_go) begin
          sram_en   = 1'b1;
          sram_addr = off_full[AW+1:2];
          stall_out = 1'b1;
          cnt_d     = CNT_INIT;
          state_d   = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        stall_out = 1'b1;
        if (cnt_q == 2'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      S_DONE: begin
        load_valid = 1'b1;
        load_data  = ld_data;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      width_q <= '0;
      off_q   <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cause_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= sample & (cause != ERR_NONE);
      cause_q <= (sample & (cause != ERR_NONE)) ? cause : ERR_NONE;
      if (ld_go) begin
        width_q <= req_width;
        off_q   <= req_addr[1:0];
        uns_q   <= req_unsigned;
      end
      if ((state_q == S_RD_WAIT) && (cnt_q == 2'd0)) rdata_q <= sram_rdata;
    end
  end

  assign err_out   = err_q;
  assign err_cause = cause_q;

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Data-memory controller directly downstream of the MEM stage. It consumes the stage's read/write strobes, width code, address and zero-extended store data, and drives a synchronous single-port 32-bit SRAM with per-byte write enables. Loads stall the pipeline until SRAM read data returns, then present lane-aligned, sign- or zero-extended data to writeback. Stores are posted in one cycle. Misaligned, out-of-range and illegal requests are flagged.

Parameters:
BASE_ADDR, 32'h0000_1000, byte address mapped to SRAM word 0 (lowest address the MEM stage emits)
DEPTH_WORDS, 4096, SRAM depth in 32-bit words; power of two
RD_LAT, 1, SRAM read latency in cycles; legal range 1..4
AW (localparam), clog2(DEPTH_WORDS), SRAM word-address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_re  in  1  load request from MEM stage
req_we  in  1  store request from MEM stage
req_width  in  2  00 byte, 01 half, 10 word, 11 invalid
req_unsigned  in  1  funct3[2] of load: 1 = zero-extend, 0 = sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, zero-extended in the low bits
stall_out  out  1  hold pipeline (combinational)
load_valid  out  1  load_data valid, one-cycle pulse
load_data  out  32  extended load result
err_out  out  1  one-cycle error pulse
err_cause  out  2  01 misaligned, 10 out of range, 11 illegal (both strobes set, or width 11)
sram_en  out  1  SRAM access enable
sram_we  out  4  byte write enables, bit i = byte lane i
sram_addr  out  AW  word address
sram_wdata  out  32  lane-replicated write data
sram_rdata  in  32  SRAM read data, valid RD_LAT cycles after the enabled read

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE. All outputs are 0, including sram_en, sram_we, load_valid, err_out, err_cause and load_data. The wait counter is 0.
- States: IDLE, RD_WAIT, DONE. Requests are sampled only in IDLE. In other states, inputs are ignored, and the pipeline holds them stable because of the stall.
- Request checks in IDLE, in priority order:
  - illegal: re&we, or width 11 on any request.
  - misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - out of range: (addr - BASE_ADDR) >= DEPTH_WORDS*4, or addr < BASE_ADDR.
- Error response: registered err_out=1 and err_cause for exactly one cycle. No SRAM access and no stall. State stays IDLE.
- Store, IDLE and legal:
  - same cycle: sram_en=1, sram_addr=(addr-BASE_ADDR)>>2.
  - byte: sram_we=1<<addr[1:0], wdata={4{d[7:0]}}.
  - half: sram_we = 4'b1100 if addr[1]=1, else 4'b0011; wdata={2{d[15:0]}}.
  - word: sram_we=4'b1111, wdata=d.
  - stall_out=0. State stays IDLE.
- Load, IDLE and legal:
  - same cycle: sram_en=1, sram_we=0, stall_out=1.
  - capture width, unsigned flag and addr[1:0]; counter=RD_LAT-1; go to RD_WAIT.
- RD_WAIT: stall_out=1. Counter decrements each cycle; at 0, register sram_rdata and go to DONE. With RD_LAT=1, the one-cycle read wait still applies.
- DONE:
  - stall_out=0, load_valid=1 for one cycle.
  - load_data = captured word shifted right by 8*off, then byte or half extended per the flag; word passes through.
  - next state is IDLE.
- Total load latency: RD_LAT+1 stalled cycles, then the DONE cycle.
- Back-to-back: a request is accepted in the first IDLE cycle after DONE.
- Outside the store or load-issue cycles, sram_en=0 and sram_we=0.
- Reset mid-load: the access is abandoned and no load_valid is produced.

Decomposition:
- Package dmem_pkg holds:
  - width codes (W_BYTE, W_HALF, W_WORD, W_INV);
  - err_cause codes;
  - the state enum;
  - the lane-enable lookup.
- Sub-module dmem_lane_align: purely combinational store lane replication/enable generation plus load extraction and extension, instantiated once.

Test Plan:
- Word store 0xDEADBEEF @0x1004, then word load @0x1004 (RD_LAT=1) -> store: sram_we=1111, sram_addr=1. Load: stall 2 cycles, then load_valid with 0xDEADBEEF.
- Byte store 0x80 @0x1007, then signed byte load @0x1007 -> sram_we=1000, wdata=0x80808080, load_data=0xFFFFFF80. Unsigned byte load @0x1007 -> 0x00000080.
- Half store 0x8001 @0x1002, then signed half load @0x1002 -> sram_we=1100, load_data=0xFFFF8001.
- Word load @0x1002 -> err_out pulse with cause 01. Half store @0x1000+DEPTH_WORDS*4 -> cause 10. re=we=1 -> cause 11. In all three cases: no sram_en, no stall.
- RD_LAT=3 load -> stall_out high 4 cycles, load_valid on the 5th cycle. Drop rst_n during RD_WAIT -> all outputs 0 immediately, no load_valid after release.
- Load immediately followed by a store on the cycle after DONE -> store issues with no gap and stall_out=0.
